// File: rtl/tof_i2c_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tof_i2c_bus_scheduler
//   Shares one I2C transaction engine between NREQ requesters. Requester 0 has
//   fixed priority; the others are served round-robin. A granted requester can
//   hold the bus across back-to-back transactions with lock_i (for example a
//   mux switch write followed by the ADC read behind it). A watchdog aborts
//   transactions the engine never completes.
// -----------------------------------------------------------------------------
module tof_i2c_bus_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 34,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ*DW-1:0] desc_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic               err_o,
    output logic [15:0]        rdata_o,
    output logic               eng_start_o,
    output logic [DW-1:0]      eng_desc_o,
    output logic               eng_abort_o,
    input  logic               eng_busy_i,
    input  logic               eng_done_i,
    input  logic               eng_nack_i,
    input  logic [15:0]        eng_rdata_i,
    output logic               timeout_o
);

    // Index width for requester numbers; timer wide enough to reach TIMEOUT.
    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ABORT,
        ST_DONE
    } state_e;

    // Registered state and outputs.
    state_e            state_q,   state_d;
    logic [WW-1:0]     win_q,     win_d;
    logic [WW-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [TW-1:0]     timer_q,   timer_d;
    logic [NREQ-1:0]   gnt_q,     gnt_d;
    logic [NREQ-1:0]   done_q,    done_d;
    logic              err_q,     err_d;
    logic [15:0]       rdata_q,   rdata_d;
    logic              start_q,   start_d;
    logic [DW-1:0]     desc_q,    desc_d;
    logic              abort_q,   abort_d;
    logic              timeout_q, timeout_d;

    // Arbitration result for the IDLE state.
    logic [WW-1:0]     arb_win;
    logic              arb_found;
    int                arb_idx;

    // Saturating timer increment and watchdog expiry compare.
    logic [TW-1:0]     timer_inc;
    logic              timer_expired;

    // Descriptors split per requester so they can be selected by index.
    logic [DW-1:0]     desc_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_desc_unpack
        assign desc_arr[g] = desc_i[g*DW +: DW];
    end

    assign timer_inc     = (timer_q == '1) ? timer_q : timer_q + TW'(1);
    assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

    // Pick the next requester: req 0 first, then round-robin over 1..NREQ-1
    // starting at rr_ptr and wrapping back to 1.
    // NOTE: every variable written in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        arb_idx   = 0;
        if (req_i[0]) begin
            arb_found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                arb_idx = int'(rr_ptr_q) + k;
                if (arb_idx >= NREQ) begin
                    arb_idx = arb_idx - (NREQ - 1);
                end
                if (!arb_found && req_i[arb_idx[WW-1:0]]) begin
                    arb_win   = arb_idx[WW-1:0];
                    arb_found = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic for the grant/issue/wait/done sequence.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        start_d   = 1'b0;
        desc_d    = desc_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    win_d   = arb_win;
                    gnt_d   = NREQ'(1) << arb_win;
                    start_d = 1'b1;
                    desc_d  = desc_arr[arb_win];
                    timer_d = '0;
                    state_d = ST_ISSUE;
                end
            end

            // Start pulse is on the wire this cycle; the watchdog counts from
            // here so that expiry lands TIMEOUT cycles after the start.
            ST_ISSUE: begin
                timer_d = timer_inc;
                state_d = ST_WAIT;
            end

            // A completion in the expiry cycle takes precedence over abort.
            ST_WAIT: begin
                timer_d = timer_inc;
                if (eng_done_i) begin
                    done_d  = NREQ'(1) << win_q;
                    err_d   = eng_nack_i;
                    rdata_d = eng_rdata_i;
                    state_d = ST_DONE;
                end else if (timer_expired) begin
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_ABORT;
                end
            end

            // Late completions from the aborted engine are ignored; only
            // busy going low ends the abort.
            ST_ABORT: begin
                if (!eng_busy_i) begin
                    done_d  = NREQ'(1) << win_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end

            // Locked requester with a clean completion keeps the bus with no
            // gap in gnt; any error forces the bus to be released.
            ST_DONE: begin
                if (lock_i[win_q] && req_i[win_q] && !err_q) begin
                    start_d = 1'b1;
                    desc_d  = desc_arr[win_q];
                    timer_d = '0;
                    state_d = ST_ISSUE;
                end else begin
                    gnt_d = '0;
                    if (win_q != '0) begin
                        rr_ptr_d = (win_q == WW'(NREQ - 1)) ? WW'(1) : win_q + WW'(1);
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to idle at once.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the edge, independent of order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            rr_ptr_q  <= WW'(1);
            timer_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            start_q   <= 1'b0;
            desc_q    <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rr_ptr_q  <= rr_ptr_d;
            timer_q   <= timer_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            start_q   <= start_d;
            desc_q    <= desc_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign eng_start_o = start_q;
    assign eng_desc_o  = desc_q;
    assign eng_abort_o = abort_q;
    assign timeout_o   = timeout_q;

endmodule
